// File: rtl/downlink_tx_arbiter.sv
// downlink_tx_arbiter: two-channel packet arbiter/framer feeding the 10-bit downlink serializer.
// Define ARB_FIXED_PRIO_EN to give channel 0 fixed priority instead of round-robin.
module downlink_tx_arbiter #(
  parameter int MAX_LEN = 256,
  parameter logic [9:0] IDLE_CODE = 10'b00000_11111,
  parameter logic [8:0] HDR_BASE = 9'b11000_0000,
  parameter logic [9:0] TRAILER = 10'b11100_00111
) (
  input  logic       CLK_10MHZ,
  input  logic       Rst,
  input  logic       LinkUp,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [9:0] Din0,
  input  logic [9:0] Din1,
  input  logic       DinEn0,
  input  logic       DinEn1,
  input  logic       DinLast0,
  input  logic       DinLast1,
  output logic       Grant0,
  output logic       Grant1,
  output logic [9:0] DownSig_Din,
  output logic       DataInEn,
  output logic       Busy,
  output logic       TruncErr
);
  localparam int CW = $clog2(MAX_LEN);
  localparam logic [1:0] S_IDLE = 2'd0, S_HEADER = 2'd1, S_PAYLOAD = 2'd2, S_TRAILER = 2'd3;
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt;
  logic last_ch, win, any_req, acc, fin, cut;
  logic [9:0] din;
  // Grant1 doubles as the owner select; it is only consulted while in PAYLOAD
  always_comb begin
    any_req = Req0 || Req1;
`ifdef ARB_FIXED_PRIO_EN
    win = !Req0;
`else
    win = (Req0 && Req1) ? !last_ch : Req1;
`endif
    acc = (state == S_PAYLOAD) && (Grant1 ? DinEn1 : DinEn0);
    din = Grant1 ? Din1 : Din0;
    fin = acc && (Grant1 ? DinLast1 : DinLast0);
    cut = acc && (cnt == CW'(MAX_LEN - 1));
    state_nx = (state == S_IDLE)    ? (any_req ? S_HEADER : S_IDLE) :
               (state == S_HEADER)  ? S_PAYLOAD :
               (state == S_PAYLOAD) ? ((fin || cut) ? S_TRAILER : S_PAYLOAD) :
                                      S_IDLE;
  end
  always_ff @(posedge CLK_10MHZ) begin
    if (Rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_ch     <= 1'b1;
      Grant0      <= 1'b0;
      Grant1      <= 1'b0;
      DownSig_Din <= '0;
      DataInEn    <= 1'b0;
      Busy        <= 1'b0;
      TruncErr    <= 1'b0;
    end else if (!LinkUp) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Grant0      <= 1'b0;
      Grant1      <= 1'b0;
      DownSig_Din <= IDLE_CODE;
      DataInEn    <= 1'b0;
      Busy        <= 1'b0;
      TruncErr    <= 1'b0;
    end else begin
      state    <= state_nx;
      Busy     <= state_nx != S_IDLE;
      TruncErr <= cut && !fin;
      case (state)
        S_IDLE: begin
          DownSig_Din <= any_req ? {HDR_BASE, win} : IDLE_CODE;
          DataInEn    <= any_req;
          if (any_req) begin
            last_ch <= win;
            Grant0  <= !win;
            Grant1  <= win;
          end
        end
        S_HEADER: begin
          DownSig_Din <= IDLE_CODE;
          DataInEn    <= 1'b0;
        end
        S_PAYLOAD: begin
          DownSig_Din <= acc ? din : IDLE_CODE;
          DataInEn    <= acc;
          if (acc && !cut) cnt <= cnt + CW'(1);
          if (fin || cut) begin
            Grant0 <= 1'b0;
            Grant1 <= 1'b0;
          end
        end
        default: begin
          DownSig_Din <= TRAILER;
          DataInEn    <= 1'b1;
          cnt         <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_downlink_tx_arbiter.sv
// tb_downlink_tx_arbiter: directed and random stimulus against a packet-level reference model.
module tb_downlink_tx_arbiter;
  localparam int MAX_LEN = 256;
  localparam logic [9:0] IDLE_CODE = 10'b00000_11111;
  localparam logic [8:0] HDR_BASE = 9'b11000_0000;
  localparam logic [9:0] TRAILER = 10'b11100_00111;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 0, rst = 1, link_up = 0, req0 = 0, req1 = 0;
  logic [9:0] din0 = 0, din1 = 0;
  logic din_en0 = 0, din_en1 = 0, din_last0 = 0, din_last1 = 0;
  logic g0, g1, en, busy, trunc;
  logic [9:0] dout;
  int vectors = 0, errors = 0, g0_cycles = 0, trunc_cnt = 0;
  logic [9:0] seen[$];
  // reference model: packet phase, owner, words sent, last channel served
  typedef enum int {P_IDLE, P_HEADER, P_PAYLOAD, P_TRAILER} phase_t;
  phase_t m_phase = P_IDLE;
  int m_words = 0;
  bit m_owner = 0, m_last = 1, m_g0 = 0, m_g1 = 0, m_en = 0, m_trunc = 0;
  logic [9:0] m_dout = 0;

  downlink_tx_arbiter #(.MAX_LEN(MAX_LEN)) dut (
    .CLK_10MHZ(clk), .Rst(rst), .LinkUp(link_up), .Req0(req0), .Req1(req1),
    .Din0(din0), .Din1(din1), .DinEn0(din_en0), .DinEn1(din_en1),
    .DinLast0(din_last0), .DinLast1(din_last1), .Grant0(g0), .Grant1(g1),
    .DownSig_Din(dout), .DataInEn(en), .Busy(busy), .TruncErr(trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model();
    bit w, take, lastw;
    if (rst) begin
      m_phase = P_IDLE; m_words = 0; m_last = 1; m_g0 = 0; m_g1 = 0;
      m_dout = 10'h000; m_en = 0; m_trunc = 0;
    end else if (!link_up) begin
      m_phase = P_IDLE; m_words = 0; m_g0 = 0; m_g1 = 0;
      m_dout = IDLE_CODE; m_en = 0; m_trunc = 0;
    end else begin
      m_trunc = 0;
      if (m_phase == P_IDLE) begin
        if (req0 || req1) begin
          w = FIXED ? !req0 : ((req0 && req1) ? !m_last : req1);
          m_owner = w; m_last = w; m_g0 = !w; m_g1 = w;
          m_dout = {HDR_BASE, w}; m_en = 1; m_phase = P_HEADER;
        end else begin
          m_dout = IDLE_CODE; m_en = 0;
        end
      end else if (m_phase == P_HEADER) begin
        m_dout = IDLE_CODE; m_en = 0; m_phase = P_PAYLOAD;
      end else if (m_phase == P_PAYLOAD) begin
        take = m_owner ? din_en1 : din_en0;
        lastw = m_owner ? din_last1 : din_last0;
        m_dout = take ? (m_owner ? din1 : din0) : IDLE_CODE;
        m_en = take;
        if (take) begin
          m_words++;
          if (lastw || m_words == MAX_LEN) begin
            m_phase = P_TRAILER; m_g0 = 0; m_g1 = 0; m_trunc = !lastw;
          end
        end
      end else begin
        m_dout = TRAILER; m_en = 1; m_words = 0; m_phase = P_IDLE;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model();
    chk("dout", dout, m_dout);
    chk("data_en", en, m_en);
    chk("grant0", g0, m_g0);
    chk("grant1", g1, m_g1);
    chk("busy", busy, m_phase != P_IDLE);
    chk("trunc_err", trunc, m_trunc);
    if (en) seen.push_back(dout);
    if (g0) g0_cycles++;
    if (trunc) trunc_cnt++;
  endtask

  function automatic bit gnt(input bit c);
    return c ? g1 : g0;
  endfunction

  task automatic drive(input bit c, input logic [9:0] d, input bit e, input bit l);
    if (c) begin din1 = d; din_en1 = e; din_last1 = l; end
    else begin din0 = d; din_en0 = e; din_last0 = l; end
  endtask

  // source side: request, present words while granted, advance on acceptance
  task automatic run_pkt(input bit c, input logic [9:0] w[$], input bit [15:0] hole);
    int idx = 0, n = w.size();
    bit pg;
    if (c) req1 = 1; else req0 = 1;
    for (int k = 0; k < 50 && !gnt(c); k++) step();
    chk("grant_rise", gnt(c), 1);
    if (c) req1 = 0; else req0 = 0;
    for (int k = 0; gnt(c) && k < 4 * MAX_LEN; k++) begin
      drive(c, idx < n ? w[idx] : 10'h000, !hole[k % 16], idx == n - 1);
      pg = gnt(c);
      step();
      if (pg && en) idx++;
    end
    chk("grant_fall", gnt(c), 0);
    drive(c, 10'h000, 0, 0);
  endtask

  task automatic drain();
    req0 = 0; req1 = 0;
    for (int k = 0; k < 30 && (g0 || g1 || busy); k++) begin
      din_en0 = g0; din_last0 = 1; din_en1 = g1; din_last1 = 1;
      step();
    end
    din_en0 = 0; din_en1 = 0; din_last0 = 0; din_last1 = 0;
    step(); step();
  endtask

  task automatic chk_seq(input string tag, input logic [9:0] exp[$]);
    chk({tag, "_len"}, 10'(seen.size()), 10'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(tag, i < seen.size() ? seen[i] : 10'h3ff, exp[i]);
  endtask

  initial begin
    logic [9:0] wq[$], hdrs[$];
    int n387;
    repeat (3) step();
    chk("rst_dout", dout, 10'h000);
    rst = 0; link_up = 1;
    repeat (4) step();
    chk("idle_dout", dout, IDLE_CODE);
    chk("idle_en", en, 0);
    // three-word packet on channel 0
    seen.delete(); g0_cycles = 0;
    wq = '{10'h155, 10'h0AA, 10'h3C3};
    run_pkt(0, wq, 16'h0);
    step(); step();
    wq = '{10'h300, 10'h155, 10'h0AA, 10'h3C3, 10'h387};
    chk_seq("pkt3", wq);
    chk("grant0_cycles", 10'(g0_cycles), 10'd4);
    // both channels held with one-word packets
    hdrs.delete();
    for (int i = 0; i < 40; i++) begin
      req0 = 1; req1 = 1;
      din0 = 10'($urandom_range(255)); din1 = 10'($urandom_range(255));
      din_en0 = g0; din_last0 = 1; din_en1 = g1; din_last1 = 1;
      step();
      if (en && dout[9:1] == HDR_BASE) hdrs.push_back(dout);
    end
    drain();
    chk("hdr_count", 10'(hdrs.size()), 10'd10);
    chk("hdr_first", hdrs[0], FIXED ? 10'h300 : 10'h301);
    for (int i = 1; i < hdrs.size(); i++)
      chk("hdr_alt", hdrs[i], FIXED ? 10'h300 : {HDR_BASE, !hdrs[i-1][0]});
    // channel 1 overruns MAX_LEN
    seen.delete(); trunc_cnt = 0; wq.delete();
    for (int i = 0; i < 300; i++) wq.push_back(10'($urandom));
    run_pkt(1, wq, 16'h0);
    step(); step();
    chk("trunc_len", 10'(seen.size()), 10'(MAX_LEN + 2));
    chk("trunc_lastword", seen[MAX_LEN], wq[MAX_LEN-1]);
    chk("trunc_trailer", seen[MAX_LEN+1], TRAILER);
    chk("trunc_pulses", 10'(trunc_cnt), 10'd1);
    // link loss mid-packet
    seen.delete(); req0 = 1;
    for (int k = 0; k < 20 && !g0; k++) step();
    chk("drop_grant", g0, 1);
    req0 = 0; din0 = 10'h011; din_en0 = 1; din_last0 = 0;
    step(); step();
    din0 = 10'h022;
    step();
    link_up = 0; din_en0 = 0;
    step();
    chk("drop_g0", g0, 0);
    chk("drop_dout", dout, IDLE_CODE);
    step();
    link_up = 1;
    step();
    n387 = 0;
    foreach (seen[i]) if (seen[i] == TRAILER) n387++;
    chk("drop_no_trailer", 10'(n387), 10'd0);
    req0 = 1; req1 = 1;
    for (int k = 0; k < 20 && !g0 && !g1; k++) step();
    chk("drop_rr", g1, FIXED ? 1'b0 : 1'b1);
    drain();
    // payload with enable gaps 1,0,0,1
    seen.delete();
    wq = '{10'h0A5, 10'h15A};
    run_pkt(1, wq, 16'b01100);
    step(); step();
    wq = '{10'h301, 10'h0A5, 10'h15A, 10'h387};
    chk_seq("gaps", wq);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(599) == 0;
      link_up = $urandom_range(39) != 0;
      if (!req0) req0 = $urandom_range(3) == 0; else if (g0) req0 = $urandom_range(2) != 0;
      if (!req1) req1 = $urandom_range(3) == 0; else if (g1) req1 = $urandom_range(2) != 0;
      din0 = 10'($urandom); din1 = 10'($urandom);
      din_en0 = $urandom_range(3) != 0; din_en1 = $urandom_range(3) != 0;
      din_last0 = $urandom_range(7) == 0; din_last1 = $urandom_range(7) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/downlink_tx_arbiter.md
# downlink_tx_arbiter

Packet arbiter and framer in front of the 10-bit downlink serializer.
- Shares the serializer between two packet sources: channel 0 is the command/status path, channel 1 is the logging-RAM readout path.
- Wraps each granted packet as header, payload, trailer, and fills every unused cycle with the idle code.
- Drives the serializer word bus only after the link handshake has completed.

## Interface
- MAX_LEN, 256: maximum payload words per packet; legal range 2..1023.
- IDLE_CODE, 10'b00000_11111: filler word.
- HDR_BASE, 9'b11000_0000: header upper 9 bits; header LSB is the channel number.
- TRAILER, 10'b11100_00111: end-of-packet word.

Ports:
- CLK_10MHZ  in  1  serializer reference clock; the only clock.
- Rst  in  1  reset, synchronous, active-high.
- LinkUp  in  1  high while the downlink handshake controller is in normal operation.
- Req0, Req1  in  1  packet request; level, held until Grant.
- Din0, Din1  in  10  payload word from channel 0 / 1.
- DinEn0, DinEn1  in  1  payload word valid.
- DinLast0, DinLast1  in  1  marks the final payload word; qualified by DinEn.
- Grant0, Grant1  out  1  channel owns the payload slot.
- DownSig_Din  out  10  word to the serializer.
- DataInEn  out  1  DownSig_Din carries a header, payload or trailer word.
- Busy  out  1  state is not IDLE.
- TruncErr  out  1  one-cycle pulse when a packet is cut at MAX_LEN.

## Operation
States: IDLE, HEADER, PAYLOAD, TRAILER.

IDLE
- If LinkUp and any request is pending: pick the winner, go to HEADER.
- On that same edge: GrantN<=1, DownSig_Din<={HDR_BASE,N}, DataInEn<=1.
- Otherwise: DownSig_Din<=IDLE_CODE, DataInEn<=0.

HEADER
- Lasts exactly 1 cycle, then goes to PAYLOAD.
- On that edge: DownSig_Din<=IDLE_CODE, DataInEn<=0.

PAYLOAD, on each edge:
- With DinEnN: DownSig_Din<=DinN, DataInEn<=1, cnt<=cnt+1.
- Without DinEnN: DownSig_Din<=IDLE_CODE, DataInEn<=0.
- If an accepted word has DinLastN=1, or cnt==MAX_LEN-1: go to TRAILER and GrantN<=0.
- If the packet was cut at MAX_LEN and DinLastN was 0: TruncErr<=1 for 1 cycle.

TRAILER
- Lasts 1 cycle. On exit: DownSig_Din<=TRAILER, DataInEn<=1, go to IDLE, cnt<=0.

Arbitration
- Round-robin. last_ch records the channel most recently granted; on a tie the other channel wins.
- Reset value of last_ch is 1, so channel 0 wins the first tie.
- A Req that drops mid-packet is ignored; the packet ends only on DinLast, MAX_LEN, or loss of LinkUp.
- Ignore DinEn from the non-granted channel and in every state other than PAYLOAD.

Counter
- cnt is $clog2(MAX_LEN) bits wide and counts accepted payload words.
- cnt never wraps: the MAX_LEN cut happens first.

## Timing
- All outputs are registered. Payload latency is 1 cycle: a word accepted at edge t is on DownSig_Din after edge t.
- Grant rises at the same edge as the header appears. A source may present its first word while in HEADER, but the word is accepted only in PAYLOAD (one cycle later); the source must hold it.
- Grant falls at the edge that accepts the last word.
- The trailer leaves one edge after the last payload word. A new header may follow on the very next edge, so back-to-back packets have no idle gap.
- LinkUp low in any state:
  - next edge forces IDLE, both Grants 0, IDLE_CODE, DataInEn 0, cnt 0;
  - no trailer is sent and TruncErr is not pulsed;
  - last_ch is kept.
- Rst=1 at an edge:
  - state IDLE, cnt 0, last_ch 1;
  - Grant0/1 0, DownSig_Din 10'b00000_00000, DataInEn 0, Busy 0, TruncErr 0.
  - Rst has priority over LinkUp.
- Busy is registered from next state, so it is high in the same cycles as HEADER, PAYLOAD and TRAILER.

## Configuration
- ARB_FIXED_PRIO_EN defined: channel 0 always wins when both channels request; last_ch has no effect.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset, then LinkUp=1 with no requests:
  - DownSig_Din=10'b00000_00000 during reset, then 10'b00000_11111 every cycle after;
  - DataInEn=0, Busy=0.
- Req0 with 3 contiguous words 0x155, 0x0AA, 0x3C3 (last on 0x3C3):
  - output sequence 0x300, IDLE_CODE, 0x155, 0x0AA, 0x3C3, 0x387;
  - Grant0 high for exactly 4 cycles.
- Req0 and Req1 both held, each sending 1-word packets:
  - headers alternate 0x300, 0x301, 0x300, ...;
  - each trailer is followed immediately by the next header.
  - Rerun with ARB_FIXED_PRIO_EN: only 0x300 appears while Req0 is held.
- Channel 1 streams 300 words with no DinLast, MAX_LEN=256:
  - exactly 256 payload words, then trailer 0x387;
  - TruncErr pulses once; Grant1 falls at the 256th accepted word.
- LinkUp dropped after 2 payload words:
  - next cycle IDLE_CODE, Grants 0, no 0x387 emitted;
  - after LinkUp returns, the next grant goes to the channel not last served.
- Payload with DinEn gaps (1,0,0,1):
  - IDLE_CODE with DataInEn=0 in the gap cycles;
  - cnt=2 at the trailer.
